// File: rtl/pipe_collision_score_if.sv
// Signal bundle between the game core (pipe generator / bird controller)
// and the collision/score block.
interface pipe_collision_score_if;
  logic       Start;
  logic [9:0] BirdPosY;
  logic [9:0] PipePosX;
  logic [9:0] PipePosY;
  logic       Lost;
  logic [7:0] Score;
  logic [7:0] HighScore;
  logic       ScoreTick;

  // Game core side: supplies positions and start, consumes results.
  modport master (
    output Start, BirdPosY, PipePosX, PipePosY,
    input  Lost, Score, HighScore, ScoreTick
  );

  // Collision/score block side.
  modport slave (
    input  Start, BirdPosY, PipePosX, PipePosY,
    output Lost, Score, HighScore, ScoreTick
  );
endinterface

// File: rtl/pipe_collision_score.sv
// Pipe/bird collision detection, floor strike, round score and session best.
// Geometry is evaluated only while a round is in play.
module pipe_collision_score #(
  parameter int unsigned BIRD_X   = 200,
  parameter int unsigned BIRD_W   = 34,
  parameter int unsigned BIRD_H   = 24,
  parameter int unsigned PIPE_W   = 52,
  parameter int unsigned GAP_HALF = 60,
  parameter int unsigned FLOOR_Y  = 480
) (
  input logic                   Clk,
  input logic                   Reset,
  pipe_collision_score_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    PLAY = 3'b010,
    LOST = 3'b100
  } state_t;

  localparam logic [10:0] BIRD_LEFT  = 11'(BIRD_X);
  localparam logic [10:0] BIRD_RIGHT = 11'(BIRD_X + BIRD_W);
  localparam logic [10:0] BIRD_HGT   = 11'(BIRD_H);
  localparam logic [10:0] PIPE_WID   = 11'(PIPE_W);
  localparam logic [10:0] GAP_HLF    = 11'(GAP_HALF);
  localparam logic [10:0] FLOOR_LINE = 11'(FLOOR_Y);

  state_t     state, state_nxt;
  logic [7:0] score, score_nxt;
  logic [7:0] high, high_nxt;
  logic       tick, tick_nxt;
  logic       scored, scored_nxt;

  logic [10:0] px, py, by;
  logic        hit_x, out_gap, floor_hit, collide, behind;

  // Widen to 11 bits so every sum below is overflow-free; compares only.
  assign px = {1'b0, bus.PipePosX};
  assign py = {1'b0, bus.PipePosY};
  assign by = {1'b0, bus.BirdPosY};

  assign hit_x     = (px < BIRD_RIGHT) && ((px + PIPE_WID) > BIRD_LEFT);
  assign out_gap   = ((by + GAP_HLF) < py) || ((by + BIRD_HGT) > (py + GAP_HLF));
  assign floor_hit = (by + BIRD_HGT) >= FLOOR_LINE;
  assign collide   = (hit_x && out_gap) || floor_hit;
  assign behind    = (px + PIPE_WID) < BIRD_LEFT;

  // Next state and next score/flag values; geometry consulted only in PLAY.
  always_comb begin
    state_nxt  = state;
    score_nxt  = score;
    high_nxt   = high;
    tick_nxt   = 1'b0;
    scored_nxt = scored;
    unique case (state)
      IDLE: begin
        if (bus.Start) begin
          state_nxt  = PLAY;
          score_nxt  = '0;
          scored_nxt = 1'b1;
        end
      end
      PLAY: begin
        // Collision takes priority over a same-cycle scoring pass.
        if (collide) begin
          state_nxt = LOST;
          high_nxt  = (score > high) ? score : high;
        end else if (behind && !scored) begin
          score_nxt  = (score == '1) ? score : score + 8'd1;
          scored_nxt = 1'b1;
          tick_nxt   = 1'b1;
        end else if (!behind) begin
          scored_nxt = 1'b0;
        end
      end
      LOST: begin
        if (bus.Start) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Score, session best, increment pulse and per-pipe scored flag.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      score  <= '0;
      high   <= '0;
      tick   <= 1'b0;
      scored <= 1'b1;
    end else begin
      score  <= score_nxt;
      high   <= high_nxt;
      tick   <= tick_nxt;
      scored <= scored_nxt;
    end
  end

  assign bus.Lost      = (state == LOST);
  assign bus.Score     = score;
  assign bus.HighScore = high;
  assign bus.ScoreTick = tick;

endmodule

// File: doc/pipe_collision_score.md
Name: pipe_collision_score

Overview:
- Sits directly downstream of the pipe generator and consumes its PipePosX/PipePosY each clock.
- Compares the pipe against the bird's position and asserts Lost on contact or floor strike. Lost feeds back to the pipe generator and to the bird controller.
- Counts pipes cleared (Score) and keeps a session best (HighScore) for the score display.

Parameters:
- BIRD_X, 200, fixed left-edge X of bird sprite (px)
- BIRD_W, 34, bird width (px)
- BIRD_H, 24, bird height (px)
- PIPE_W, 52, pipe width (px)
- GAP_HALF, 60, half-height of pipe gap centred on PipePosY (px)
- FLOOR_Y, 480, Y of ground line (px)

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  start/restart request, level, sampled each clock
- BirdPosY  in  10  bird top-edge Y (px, 0 = top)
- PipePosX  in  10  pipe left-edge X from pipe generator
- PipePosY  in  10  pipe gap centre Y from pipe generator
- Lost  out  1  registered; high while in LOST state
- Score  out  8  pipes cleared this round, binary, saturating
- HighScore  out  8  best Score since Reset
- ScoreTick  out  1  one-cycle pulse on each Score increment

Behaviour:
- Reset (async, Reset=1): state=IDLE, Lost=0, Score=0, HighScore=0, ScoreTick=0, internal Scored flag=1.
- All geometry arithmetic is done in 11 bits unsigned. No subtraction is used.
  - HitX = (PipePosX < BIRD_X+BIRD_W) && (PipePosX+PIPE_W > BIRD_X)
  - OutGap = (BirdPosY+GAP_HALF < PipePosY) || (BirdPosY+BIRD_H > PipePosY+GAP_HALF)
  - Floor = (BirdPosY+BIRD_H >= FLOOR_Y)
  - Collide = (HitX && OutGap) || Floor
  - Behind = (PipePosX+PIPE_W < BIRD_X)
- States: IDLE, PLAY, LOST (one-hot, 3 bits).
- IDLE:
  - Inputs ignored, Lost=0.
  - Start=1 -> PLAY next cycle; Score<=0 and Scored<=1 on that edge.
- PLAY, evaluated every clock:
  - Collide=1 -> LOST next edge. Lost goes high on that edge (1-cycle latency from the input sample). HighScore<=max(HighScore,Score) on the same edge. No score change that cycle.
  - Else if Behind && !Scored -> Score<=Score+1 (holds at 255 if already 255), Scored<=1, ScoreTick<=1 for exactly one cycle. ScoreTick pulses even when Score is saturated.
  - Else if !Behind -> Scored<=0, re-arming after pipe respawns at right edge (PipePosX=1000).
  - Scored=1 at PLAY entry, so a pipe already behind the bird at Start does not score.
- LOST:
  - Lost=1 held; Score and HighScore frozen.
  - Start=1 -> IDLE next edge, Lost<=0.
  - Start held continuously gives LOST->IDLE->PLAY on consecutive edges.
- Simultaneous Collide and Behind-scoring in one cycle: collision wins, Score unchanged.
- Start in PLAY: ignored.
- ScoreTick is 0 in every cycle other than an increment edge.
- Reset asserted mid-round: immediate return to reset values, including HighScore.
- Unknown/X pipe inputs while in IDLE must not propagate to outputs (IDLE does not evaluate geometry).

Test Plan:
- Reset, Start=1 one cycle, BirdPosY=200, PipePosY=230, PipePosX sweeps 1000->0 -> Lost stays 0. Score=1 with one ScoreTick pulse the cycle after PipePosX becomes 147 (147+52<200).
- PLAY, PipePosX=220, PipePosY=300, BirdPosY=100 -> Lost=1 exactly one clock later. HighScore updated to current Score.
- PLAY, no pipe overlap (PipePosX=900), BirdPosY=456 (456+24=480) -> Lost=1 next edge. BirdPosY=455 -> no Lost.
- Same-cycle edge case: PipePosX steps to 147 while BirdPosY=459 (floor hit) -> Lost=1, Score unchanged, no ScoreTick.
- Force 260 pipe passes -> Score saturates at 255, ScoreTick still pulses per pass. LOST then Start -> IDLE, then Start -> PLAY with Score=0 and HighScore=255.
- Assert Reset mid-PLAY with Score=5 -> all outputs 0 asynchronously, state IDLE. Start required to resume.
